pixel_load_ctrl: RTL and testbench
==================================

Name: pixel_load_ctrl

Overview:
- FPGA-side sequencer for the HPS pixel PIO channel.
- HPS software presents one 24-bit pixel plus control bits on the PIO exports. The block handshakes each pixel with a toggle protocol and writes it to the frame buffer write port at a linearly advancing address.
- It reports the current row and status back to the HPS through the 16-bit row and 4-bit status read PIOs.
- Sits between the Qsys system outputs and the VGA frame buffer.

Parameters:
H_RES, 640, pixels per row
V_RES, 480, rows per frame
ADDR_W, 19, frame buffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES

Ports:
clk_clk  in  1  system clock; same clock as the Qsys PIOs and the frame buffer write port
reset_reset_n  in  1  asynchronous active-low reset
pixel_data  in  24  RGB888 pixel from the HPS data PIO
status_w  in  4  HPS control: [0] req toggle, [1] sof, [2] abort, [3] reserved (ignored)
pixel_row  out  16  current row index, zero-extended, to the HPS row PIO
status_r  out  4  to HPS: [0] ack toggle, [1] frame_done, [2] busy, [3] overrun
fb_addr  out  ADDR_W  frame buffer write address
fb_data  out  24  frame buffer write data
fb_we  out  1  write request; held with addr/data until accepted
fb_ready  in  1  frame buffer accepts the write on a rising edge where fb_we=1 and fb_ready=1
frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, sync flops 0.
- Input synchronisation:
  - status_w passes through 2 flops (s1, s2), then one more register s2_d for edge detect.
  - pixel_data is captured unsynchronised at the moment a request is recognised. The HPS writes data before toggling req, so the data is stable by then.
- Request definition:
  - pending = s2[0] XOR status_r[0].
  - sof_edge = s2[1] AND NOT s2_d[1].
  - abort = s2[2] (level).
- Priority each cycle: abort > sof_edge > FSM transition.
- abort (any state):
  - Go to IDLE; fb_we<=0.
  - col, row, fb_addr <= 0; pixel_row <= 0.
  - status_r[1] and status_r[2] cleared; ack and overrun unchanged.
  - Block remains in IDLE while abort is high.
- sof_edge (any state, abort low):
  - col, row, fb_addr <= 0; fb_we<=0.
  - status_r[0] <= s2[0], so stale toggles are discarded.
  - Clear frame_done level and overrun; go to WAIT_REQ.
- States:
  - IDLE: ignores req; busy=0; leaves only on sof_edge.
  - WAIT_REQ: busy=1. If pending: fb_data<=pixel_data, fb_addr<=addr counter, fb_we<=1, go to WRITE.
  - WRITE: busy=1; fb_we, fb_addr, fb_data held stable.
    - While waiting: if s2[0] != s2_d[0] (a second req toggle before ack), set overrun sticky. That pixel is lost; the FSM does not restart.
    - On fb_ready: fb_we<=0, status_r[0] toggles, address counter +1, col+1.
    - If col==H_RES-1: col<=0, row+1, pixel_row<=row+1.
    - If col==H_RES-1 and row==V_RES-1: go to DONE, frame_done pulse 1 cycle, status_r[1]<=1, pixel_row<=V_RES, address counter holds.
    - Otherwise return to WAIT_REQ.
  - DONE: busy=0; further req toggles ignored and ack does not toggle; leaves only on sof_edge or abort.
- Latency (fb_ready tied 1):
  - status_w[0] toggles before edge k.
  - s2 updates at edge k+1.
  - fb_we visible after edge k+2.
  - Accepted at edge k+3, with ack toggle and row/addr update visible after k+3.
  - Maximum pixel rate is one per 4 cycles plus software loop time.
- Backpressure: fb_ready low for N cycles delays the ack by N cycles; no data change during the stall.
- Address arithmetic: fb_addr is a linear counter 0..H_RES*V_RES-1 with no multiply. col and row widths are sized by clog2 of H_RES and V_RES.
- Reset mid-write: fb_we drops asynchronously; no partial state survives.

Test Plan:
1. Reset, sof, then 3 req toggles with pixel_data 0xFF0000, 0x00FF00, 0x0000FF and fb_ready=1 -> writes at addr 0,1,2 with that data. Each ack toggles 3 cycles after its req. pixel_row=0; busy=1.
2. Row wrap: 640 pixels -> after the 640th accept, pixel_row=1 and the next write uses addr 640. Full 307200 pixels -> frame_done pulses once, status_r[1]=1, busy=0, pixel_row=480. A further toggle produces no write and no ack.
3. Backpressure: fb_ready=0 for 5 cycles after fb_we asserts -> addr/data stable, ack delayed 5 cycles, exactly one write.
4. Overrun: toggle req twice during a stalled WRITE -> status_r[3]=1 and exactly one write. The next sof clears overrun and resyncs ack to req.
5. Abort mid-frame at pixel 1000 -> IDLE, fb_we=0, pixel_row=0, busy=0. Req toggles are ignored until sof; after sof, the first write is at addr 0.
6. Async reset asserted during WRITE with fb_ready=0 -> fb_we and all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/pixel_load_ctrl.sv
// HPS pixel PIO sequencer: synchronises the req/sof/abort controls, handshakes each
// pixel with a toggle ack and streams it into the frame buffer at a linear address.
module pixel_load_ctrl #(
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned ADDR_W = 19
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [23:0]       pixel_data,
  input  logic [3:0]        status_w,
  output logic [15:0]       pixel_row,
  output logic [3:0]        status_r,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [23:0]       fb_data,
  output logic              fb_we,
  input  logic              fb_ready,
  output logic              frame_done
);

  localparam int unsigned COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_RES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_REQ, WRITE, DONE} state_t;

  state_t            r_state;
  logic [2:0]        r_s1;
  logic [2:0]        r_s2;
  logic [1:0]        r_s2_d;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_addr;
  logic              r_ack;
  logic              r_done_lvl;
  logic              r_busy;
  logic              r_ovr;
  logic [15:0]       r_pixel_row;
  logic [ADDR_W-1:0] r_fb_addr;
  logic [23:0]       r_fb_data;
  logic              r_fb_we;
  logic              r_frame_done;

  logic w_pending;
  logic w_sof_edge;
  logic w_abort;
  logic w_req_edge;
  logic w_unused;

  // status_w[3] is reserved and deliberately not synchronised
  assign w_unused   = status_w[3];
  assign w_pending  = r_s2[0] ^ r_ack;
  assign w_sof_edge = r_s2[1] & ~r_s2_d[1];
  assign w_abort    = r_s2[2];
  assign w_req_edge = r_s2[0] ^ r_s2_d[0];

  assign status_r   = {r_ovr, r_busy, r_done_lvl, r_ack};
  assign pixel_row  = r_pixel_row;
  assign fb_addr    = r_fb_addr;
  assign fb_data    = r_fb_data;
  assign fb_we      = r_fb_we;
  assign frame_done = r_frame_done;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state      <= IDLE;
      r_s1         <= '0;
      r_s2         <= '0;
      r_s2_d       <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_addr       <= '0;
      r_ack        <= 1'b0;
      r_done_lvl   <= 1'b0;
      r_busy       <= 1'b0;
      r_ovr        <= 1'b0;
      r_pixel_row  <= '0;
      r_fb_addr    <= '0;
      r_fb_data    <= '0;
      r_fb_we      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_s1         <= status_w[2:0];
      r_s2         <= r_s1;
      r_s2_d       <= r_s2[1:0];
      r_frame_done <= 1'b0;

      if (w_abort) begin
        r_state     <= IDLE;
        r_fb_we     <= 1'b0;
        r_col       <= '0;
        r_row       <= '0;
        r_addr      <= '0;
        r_fb_addr   <= '0;
        r_pixel_row <= '0;
        r_done_lvl  <= 1'b0;
        r_busy      <= 1'b0;
      end else if (w_sof_edge) begin
        // Adopting the current req level as ack discards any stale toggle
        r_state     <= WAIT_REQ;
        r_fb_we     <= 1'b0;
        r_col       <= '0;
        r_row       <= '0;
        r_addr      <= '0;
        r_fb_addr   <= '0;
        r_pixel_row <= '0;
        r_ack       <= r_s2[0];
        r_done_lvl  <= 1'b0;
        r_ovr       <= 1'b0;
        r_busy      <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            r_busy <= 1'b0;
          end
          WAIT_REQ: begin
            r_busy <= 1'b1;
            if (w_pending) begin
              r_fb_data <= pixel_data;
              r_fb_addr <= r_addr;
              r_fb_we   <= 1'b1;
              r_state   <= WRITE;
            end
          end
          WRITE: begin
            r_busy <= 1'b1;
            if (w_req_edge) begin
              r_ovr <= 1'b1;
            end
            if (fb_ready) begin
              r_fb_we <= 1'b0;
              r_ack   <= ~r_ack;
              if (r_col == COL_LAST) begin
                r_col <= '0;
                if (r_row == ROW_LAST) begin
                  // Last pixel: address counter and row hold until the next sof
                  r_state      <= DONE;
                  r_frame_done <= 1'b1;
                  r_done_lvl   <= 1'b1;
                  r_busy       <= 1'b0;
                  r_pixel_row  <= 16'(V_RES);
                end else begin
                  r_row       <= r_row + ROW_W'(1);
                  r_pixel_row <= 16'(r_row) + 16'd1;
                  r_addr      <= r_addr + ADDR_W'(1);
                  r_state     <= WAIT_REQ;
                end
              end else begin
                r_col   <= r_col + COL_W'(1);
                r_addr  <= r_addr + ADDR_W'(1);
                r_state <= WAIT_REQ;
              end
            end
          end
          DONE: begin
            r_busy <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_load_ctrl.sv
// Directed bench for pixel_load_ctrl on a reduced 8x4 frame.
module tb_pixel_load_ctrl;

  localparam int unsigned H  = 8;
  localparam int unsigned V  = 4;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [23:0]   pixel_data = '0;
  logic [3:0]    status_w = '0;
  logic [15:0]   pixel_row;
  logic [3:0]    status_r;
  logic [AW-1:0] fb_addr;
  logic [23:0]   fb_data;
  logic          fb_we;
  logic          fb_ready = 1'b1;
  logic          frame_done;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int fd_count = 0;
  logic [AW-1:0] last_addr = '0;
  logic [23:0]   last_data = '0;
  logic          req = 1'b0;

  always #5 clk = ~clk;

  pixel_load_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .pixel_data    (pixel_data),
    .status_w      (status_w),
    .pixel_row     (pixel_row),
    .status_r      (status_r),
    .fb_addr       (fb_addr),
    .fb_data       (fb_data),
    .fb_we         (fb_we),
    .fb_ready      (fb_ready),
    .frame_done    (frame_done)
  );

  // Inputs only change just after posedge, so a negedge sample sees what the next edge accepts
  always @(negedge clk) begin
    if (rst_n && fb_we && fb_ready) begin
      wr_count++;
      last_addr = fb_addr;
      last_data = fb_data;
    end
    if (frame_done) fd_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic toggle_req();
    req = !req;
    status_w[0] = req;
  endtask

  task automatic do_sof();
    status_w[1] = 1'b1;
    repeat (4) tick();
    status_w[1] = 1'b0;
    repeat (2) tick();
  endtask

  // One pixel with exact latency checks; fb_ready must be 1
  task automatic px_lat(input string tag, input logic [23:0] data, input logic [AW-1:0] exp_addr);
    pixel_data = data;
    toggle_req();
    repeat (3) tick();
    chk({tag, "_we"},    32'(fb_we), 32'd1);
    chk({tag, "_addr"},  32'(fb_addr), 32'(exp_addr));
    chk({tag, "_data"},  32'(fb_data), 32'(data));
    chk({tag, "_ack0"},  32'(status_r[0]), 32'(!req));
    tick();
    chk({tag, "_ack1"},  32'(status_r[0]), 32'(req));
    chk({tag, "_we0"},   32'(fb_we), 32'd0);
  endtask

  task automatic send_pixel(input logic [23:0] data);
    int n;
    pixel_data = data;
    toggle_req();
    n = 0;
    while (status_r[0] !== req && n < 30) begin
      tick();
      n++;
    end
    chk("ack_wait", 32'(status_r[0]), 32'(req));
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_status", 32'(status_r), 32'd0);
    chk("rst_row",    32'(pixel_row), 32'd0);
    chk("rst_we",     32'(fb_we), 32'd0);
    chk("rst_addr",   32'(fb_addr), 32'd0);
    chk("rst_data",   32'(fb_data), 32'd0);
    chk("rst_fd",     32'(frame_done), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic three-pixel sequence
    do_sof();
    chk("sof_busy", 32'(status_r[2]), 32'd1);
    px_lat("p0", 24'hFF0000, 5'd0);
    px_lat("p1", 24'h00FF00, 5'd1);
    px_lat("p2", 24'h0000FF, 5'd2);
    chk("t1_wr",   32'(wr_count), 32'd3);
    chk("t1_row",  32'(pixel_row), 32'd0);
    chk("t1_busy", 32'(status_r[2]), 32'd1);

    // Row wrap and end of frame
    for (int i = 3; i < 8; i++) send_pixel(24'(i * 3 + 1));
    chk("wrap_row", 32'(pixel_row), 32'd1);
    px_lat("p8", 24'h123456, 5'd8);
    for (int i = 9; i < 32; i++) send_pixel(24'(i * 3 + 1));
    chk("fd_pulse",  32'(frame_done), 32'd1);
    tick();
    chk("fd_low",    32'(frame_done), 32'd0);
    chk("fd_count",  32'(fd_count), 32'd1);
    chk("f_wr",      32'(wr_count), 32'd32);
    chk("f_last_a",  32'(last_addr), 32'd31);
    chk("f_last_d",  32'(last_data), 32'd94);
    chk("f_done",    32'(status_r[1]), 32'd1);
    chk("f_busy",    32'(status_r[2]), 32'd0);
    chk("f_row",     32'(pixel_row), 32'd4);
    toggle_req();
    repeat (8) tick();
    chk("done_nowr", 32'(wr_count), 32'd32);
    chk("done_noack", 32'(status_r[0]), 32'(!req));

    // Backpressure: five stalled cycles
    do_sof();
    chk("bp_resync", 32'(status_r[0]), 32'(req));
    chk("bp_doneclr", 32'(status_r[1]), 32'd0);
    fb_ready = 1'b0;
    pixel_data = 24'hA5A5A5;
    toggle_req();
    repeat (3) tick();
    chk("bp_we", 32'(fb_we), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_addr", 32'(fb_addr), 32'd0);
      chk("bp_data", 32'(fb_data), 32'hA5A5A5);
    end
    chk("bp_ack0", 32'(status_r[0]), 32'(!req));
    fb_ready = 1'b1;
    tick();
    chk("bp_ack1", 32'(status_r[0]), 32'(req));
    chk("bp_wr",   32'(wr_count), 32'd33);

    // Overrun: two extra toggles during a stalled write
    fb_ready = 1'b0;
    pixel_data = 24'h0F0F0F;
    toggle_req();
    repeat (3) tick();
    chk("ov_addr", 32'(fb_addr), 32'd1);
    chk("ov_pre",  32'(status_r[3]), 32'd0);
    toggle_req();
    repeat (3) tick();
    toggle_req();
    repeat (3) tick();
    chk("ov_set",  32'(status_r[3]), 32'd1);
    fb_ready = 1'b1;
    repeat (6) tick();
    chk("ov_wr",   32'(wr_count), 32'd34);
    chk("ov_data", 32'(last_data), 32'h0F0F0F);
    do_sof();
    chk("ov_clr",  32'(status_r[3]), 32'd0);
    chk("ov_sync", 32'(status_r[0]), 32'(req));

    // Abort mid-frame after ten pixels
    for (int i = 0; i < 10; i++) send_pixel(24'(i + 100));
    chk("ab_row_pre", 32'(pixel_row), 32'd1);
    status_w[2] = 1'b1;
    repeat (3) tick();
    chk("ab_we",   32'(fb_we), 32'd0);
    chk("ab_row",  32'(pixel_row), 32'd0);
    chk("ab_busy", 32'(status_r[2]), 32'd0);
    chk("ab_addr", 32'(fb_addr), 32'd0);
    toggle_req();
    repeat (8) tick();
    status_w[2] = 1'b0;
    repeat (4) tick();
    toggle_req();
    repeat (8) tick();
    chk("ab_nowr", 32'(wr_count), 32'd44);
    do_sof();
    px_lat("ab_first", 24'h00BEEF, 5'd0);
    chk("ab_wr", 32'(wr_count), 32'd45);

    // Asynchronous reset during a stalled write
    fb_ready = 1'b0;
    pixel_data = 24'h777777;
    toggle_req();
    repeat (3) tick();
    chk("ar_we_pre", 32'(fb_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_we",     32'(fb_we), 32'd0);
    chk("ar_status", 32'(status_r), 32'd0);
    chk("ar_row",    32'(pixel_row), 32'd0);
    chk("ar_addr",   32'(fb_addr), 32'd0);
    chk("ar_data",   32'(fb_data), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    fb_ready = 1'b1;
    toggle_req();
    repeat (8) tick();
    chk("ar_idle_we", 32'(fb_we), 32'd0);
    chk("ar_idle_wr", 32'(wr_count), 32'd45);
    chk("ar_busy",    32'(status_r[2]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
